// File: rtl/csa_pkg.sv
// Shared types, default widths and the majority helper for the carry-save
// stream accumulator slice.
package csa_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 9;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand-in / result-out handshake bundle for the carry-save accumulator.
interface csa_stream_accumulator_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 9
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/csa_row.sv
// One row of full adders forming a W-bit 3:2 compressor; the carry vector is
// returned unweighted so the parent decides how to shift and drop the MSB.
module csa_row #(
  parameter int W = 12
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c_unshifted
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (z[i]),
      .sum  (s[i]),
      .cout (c_unshifted[i])
    );
  end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell; carry is the majority of the three inputs.
module full_adder
  import csa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Packet accumulator: carry-save sum per beat, iterative carry resolution after
// the last beat, then the binary total is held on a valid/ready output.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  csa_stream_accumulator_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] sum_q;
  logic [ACC_W-1:0] carry_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic [ACC_W-1:0] row_x;
  logic [ACC_W-1:0] row_s;
  logic [ACC_W-1:0] row_c;
  logic             in_ready_int;
  logic             accept;
  logic             result_taken;
  logic             carry_zero;

  // A single compressor row serves both phases: with a zero third operand it
  // performs the S^C / S&C step of carry resolution.
  assign row_x        = (state == ACCUM) ? ACC_W'(bus.in_data) : '0;
  assign in_ready_int = (state == ACCUM);
  assign accept       = bus.in_valid && in_ready_int;
  assign result_taken = (state == DONE) && bus.out_ready;
  assign carry_zero   = (carry_q == '0);

  csa_row #(.W(ACC_W)) u_row (
    .x           (sum_q),
    .y           (carry_q),
    .z           (row_x),
    .s           (row_s),
    .c_unshifted (row_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && bus.in_last) state_next = RESOLVE;
      RESOLVE: if (carry_zero)            state_next = DONE;
      DONE:    if (bus.out_ready)         state_next = ACCUM;
      default:                            state_next = ACCUM;
    endcase
  end

  // Every carry pushed past the MSB is exactly 2^ACC_W lost, so a sticky flag
  // on those drops tracks true overflow of the packet sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept || ((state == RESOLVE) && !carry_zero)) begin
      sum_q   <= row_s;
      carry_q <= {row_c[ACC_W-2:0], 1'b0};
      if (row_c[ACC_W-1]) ovf_q <= 1'b1;
      if (accept && (count_q != '1)) count_q <= count_q + CNT_W'(1);
    end else if (result_taken) begin
      sum_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready_int;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_count = '0;
    bus.out_ovf   = 1'b0;
    if (state == DONE) begin
      bus.out_valid = 1'b1;
      bus.out_data  = sum_q;
      bus.out_count = count_q;
      bus.out_ovf   = ovf_q;
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench: directed and random packets compared against a plain
// integer-sum model of the packet total, count and overflow.
module tb_csa_stream_accumulator;

  localparam int WIDTH = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 9;
  localparam int MODULUS = 1 << ACC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  csa_stream_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic idleCycle();
    bus.in_valid = 1'b0;
    bus.in_data  = WIDTH'($urandom_range(15));
    bus.in_last  = 1'($urandom_range(1));
    @(posedge clk); #1;
  endtask

  task automatic sendBeat(input int d, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(d);
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Sends a whole packet with optional random idle gaps and returns the plain
  // integer sum of its operands.
  task automatic applyStimulus(input int vals[$], input int gapPct, output int total);
    total = 0;
    foreach (vals[i]) begin
      for (int g = 0; g < 8 && $urandom_range(99) < gapPct; g++) idleCycle();
      sendBeat(vals[i], i == vals.size() - 1);
      total += vals[i];
    end
  endtask

  task automatic collectResult(input string tag, input int total, input int beats);
    int guard;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < ACC_W + 8) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_data"},  32'(bus.out_data),  32'(total % MODULUS));
    checkOutput({tag, "_count"}, 32'(bus.out_count), 32'((beats > CNT_MAX) ? CNT_MAX : beats));
    checkOutput({tag, "_ovf"},   32'(bus.out_ovf),   32'(total >= MODULUS));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_cleared_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_cleared_data"},  32'(bus.out_data),  32'd0);
    checkOutput({tag, "_ready_again"},   32'(bus.in_ready),  32'd1);
  endtask

  task automatic runPacket(input string tag, input int vals[$], input int gapPct);
    int total;
    applyStimulus(vals, gapPct, total);
    collectResult(tag, total, vals.size());
  endtask

  initial begin
    int q[$];
    int total;
    assertCount = 0;
    failCount   = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
    checkOutput("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    q = '{5, 9, 7};
    runPacket("p579", q, 0);

    // Single beat: RESOLVE sees no carry, so DONE two cycles after accept.
    sendBeat(15, 1'b1);
    checkOutput("single_lat1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("single_lat2_valid", 32'(bus.out_valid), 32'd1);
    collectResult("single15", 15, 1);

    q = {};
    for (int i = 0; i < 273; i++) q.push_back(15);
    runPacket("b273", q, 0);
    q.push_back(15);
    runPacket("b274", q, 0);

    q = {};
    for (int i = 0; i < 520; i++) q.push_back(15);
    runPacket("b520_sat", q, 0);

    // Stall in DONE with a beat offered; it must not be taken.
    q = '{4, 4};
    applyStimulus(q, 0, total);
    while (bus.out_valid !== 1'b1 && total < 1000) begin
      @(posedge clk); #1;
      total += 100;
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd9;
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      checkOutput("stall_valid",    32'(bus.out_valid), 32'd1);
      checkOutput("stall_data",     32'(bus.out_data),  32'd8);
      checkOutput("stall_count",    32'(bus.out_count), 32'd2);
      checkOutput("stall_in_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    collectResult("stall_result", 8, 2);
    q = '{6};
    runPacket("after_stall", q, 0);

    for (int p = 0; p < 3; p++) begin
      q = {};
      for (int i = 0; i < 40; i++) q.push_back(int'($urandom_range(15)));
      runPacket($sformatf("rand40_%0d", p), q, 50);
    end

    q = {};
    for (int i = 0; i < 330; i++) q.push_back(int'($urandom_range(15)));
    runPacket("rand330", q, 20);

    // Abort while carries are still being resolved.
    q = '{15, 1};
    applyStimulus(q, 0, total);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_out_data",  32'(bus.out_data),  32'd0);
    checkOutput("abort_out_count", 32'(bus.out_count), 32'd0);
    checkOutput("abort_out_ovf",   32'(bus.out_ovf),   32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    q = '{1, 2};
    runPacket("post_abort", q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
